pc_sequencer: RTL

//  Program counter / fetch sequencer directly downstream of the ALU.

---
 rtl/definitions.sv | 13 +
 rtl/pc_next_calc.sv | 32 +++
 rtl/pc_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/definitions.sv
// Shared types and constants for the program-counter sequencer.
package definitions;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam int PC_W_DEFAULT = 10;
  localparam int BOFFSET_W    = 9;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: soft reset, relative branch with modulo-2**PC_W wrap,
// or plain increment.
module pc_next_calc
  import definitions::*;
#(
  parameter int PC_W       = PC_W_DEFAULT,
  parameter int START_ADDR = 0
) (
  input  logic [PC_W-1:0]      pc,
  input  logic [BOFFSET_W-1:0] boffset,
  input  logic                 bsign,
  input  logic                 branch,
  input  logic                 soft_rst,
  output logic [PC_W-1:0]      next_pc
);

  // One spare bit above the PC keeps the borrow/carry out of the result;
  // dropping it on truncation gives the wrap.
  logic [PC_W:0] off_ext;
  assign off_ext = (PC_W+1)'(boffset);

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (soft_rst) begin
      next_pc = PC_W'(START_ADDR);
    end else if (branch) begin
      next_pc = bsign ? PC_W'({1'b0, pc} - off_ext)
                      : PC_W'({1'b0, pc} + off_ext);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer: IDLE/RUN/HALTED control, PC register
// and saturating retired-instruction counter.
module pc_sequencer
  import definitions::*;
#(
  parameter int PC_W       = PC_W_DEFAULT,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 STALL,
  input  logic                 BRANCH,
  input  logic [BOFFSET_W-1:0] BOFFSET,
  input  logic                 BSIGN,
  input  logic                 SOFT_RST,
  input  logic                 HALT,
  output logic [PC_W-1:0]      PC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CNT_W-1:0]     INSN_CNT
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  pc_state_t        state, state_next;
  logic [PC_W-1:0]  pc_next, calc_pc;
  logic [CNT_W-1:0] cnt_next, cnt_sat;

  pc_next_calc #(
    .PC_W       (PC_W),
    .START_ADDR (START_ADDR)
  ) u_next_calc (
    .pc       (PC),
    .boffset  (BOFFSET),
    .bsign    (BSIGN),
    .branch   (BRANCH),
    .soft_rst (SOFT_RST),
    .next_pc  (calc_pc)
  );

  assign cnt_sat = (&INSN_CNT) ? INSN_CNT : INSN_CNT + CNT_W'(1);

  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_next = state;
    pc_next    = PC;
    cnt_next   = INSN_CNT;
    case (state)
      IDLE, HALTED: begin
        if (START) begin
          state_next = RUN;
          pc_next    = START_PC;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (!STALL) begin
          cnt_next = cnt_sat;
          if (HALT) begin
            state_next = HALTED;
            if (SOFT_RST) pc_next = START_PC;
          end else begin
            pc_next = calc_pc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // BUSY/DONE are flopped from the next state so they line up with the
  // registered state and carry no input-to-output path.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!RESET_N) begin
      state    <= IDLE;
      PC       <= START_PC;
      INSN_CNT <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_next;
      PC       <= pc_next;
      INSN_CNT <= cnt_next;
      BUSY     <= (state_next == RUN);
      DONE     <= (state_next == HALTED);
    end
  end

endmodule
